// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - handshaked byte/half/word data memory with one outstanding request
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_ctrl #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              req_err;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lane;
    logic [31:0]       rd_word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              sign_fill;
    logic [31:0]       load_data;
    logic              unused_addr_bits;
    logic [31:0]       mem [DEPTH];

    assign word_idx         = req_addr[2 +: IDX_W];
    assign lane             = req_addr[1:0];
    assign unused_addr_bits = ^req_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end
`else
    assign req_err = 1'b0;
`endif

    // Store data is replicated across lanes so each enabled lane picks its own copy.
    always_comb begin
        byte_en    = 4'b1111;
        wdata_lane = req_wdata;
        case (req_size)
            2'b00: begin
                byte_en    = 4'b0001 << lane;
                wdata_lane = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_lane = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept && req_write && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    assign rd_word   = mem[word_idx];
    assign byte_sel  = rd_word[{lane, 3'b000} +: 8];
    assign half_sel  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        sign_fill = 1'b0;
        case (req_size)
            2'b00: begin
                sign_fill = ~req_unsigned & byte_sel[7];
                load_data = {{24{sign_fill}}, byte_sel};
            end
            2'b01: begin
                sign_fill = ~req_unsigned & half_sel[15];
                load_data = {{16{sign_fill}}, half_sel};
            end
            default: load_data = rd_word;
        endcase
    end

    // Response is captured once at accept and held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_err   <= req_err;
            resp_rdata <= (req_write || req_err) ? 32'h0 : load_data;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(64), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [1:0] sz, input logic un,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.write = wr; v.size = sz; v.uns = un; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        req_valid    = 1'b1;
        req_write    = v.write;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    // One full transaction: wait for ready, accept, hold response for 'stall' cycles, release.
    task automatic issue(input vec_t v, input int stall, input string name);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: req_ready timeout got 0 expected 1", name);
        end
        drive(v);
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        chk({name, " valid"}, 32'(resp_valid), 32'd1);
        chk({name, " rdata"}, resp_rdata, e.rdata);
        chk({name, " err"}, 32'(resp_err), 32'(e.err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, " hold valid"}, 32'(resp_valid), 32'd1);
            chk({name, " hold ready"}, 32'(req_ready), 32'd0);
            chk({name, " hold rdata"}, resp_rdata, e.rdata);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;

        add(1, 2'b10, 0, 32'h34,  32'h0000_0056, 32'h0, 0);
        add(1, 2'b10, 0, 32'h40,  32'h0000_0036, 32'h0, 0);
        add(0, 2'b10, 0, 32'h34,  32'h0, 32'h0000_0056, 0);
        add(1, 2'b10, 0, 32'h10,  32'h1122_3344, 32'h0, 0);
        add(1, 2'b00, 0, 32'h12,  32'hFFFF_FFAB, 32'h0, 0);
        add(0, 2'b10, 0, 32'h10,  32'h0, 32'h11AB_3344, 0);
        add(0, 2'b00, 0, 32'h12,  32'h0, 32'hFFFF_FFAB, 0);
        add(0, 2'b00, 1, 32'h12,  32'h0, 32'h0000_00AB, 0);
        add(0, 2'b01, 0, 32'h12,  32'h0, 32'h0000_11AB, 0);
        add(0, 2'b00, 0, 32'h13,  32'h0, 32'h0000_0011, 0);
        add(0, 2'b10, 1, 32'h10,  32'h0, 32'h11AB_3344, 0);
        add(1, 2'b01, 0, 32'h16,  32'hDEAD_8001, 32'h0, 0);
        add(0, 2'b01, 0, 32'h16,  32'h0, 32'hFFFF_8001, 0);
        add(0, 2'b01, 1, 32'h16,  32'h0, 32'h0000_8001, 0);
        add(1, 2'b10, 0, 32'h104, 32'hCAFE_BABE, 32'h0, 0);
        add(0, 2'b10, 0, 32'h004, 32'h0, 32'hCAFE_BABE, 0);
        add(1, 2'b10, 0, 32'h20,  32'h0102_0304, 32'h0, 0);
        add(1, 2'b10, 0, 32'h22,  32'h5566_7788, 32'h0, MIS);
        add(0, 2'b10, 0, 32'h20,  32'h0, MIS ? 32'h0102_0304 : 32'h5566_7788, 0);
        add(0, 2'b11, 0, 32'h20,  32'h0, MIS ? 32'h0 : 32'h5566_7788, MIS);
        add(0, 2'b01, 0, 32'h21,  32'h0, MIS ? 32'h0 : 32'h0000_7788, MIS);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i], i % 3, $sformatf("vec%0d", i));
        end

        // Backpressure with a second request held on req_valid.
        @(negedge clk);
        v = vecs[2];
        drive(v);
        sb.push_back('{rdata: 32'h0000_0056, err: 1'b0});
        @(posedge clk);
        #1 drive(vecs[5]);
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp valid", 32'(resp_valid), 32'd1);
            chk("bp req_ready", 32'(req_ready), 32'd0);
            chk("bp rdata", resp_rdata, e.rdata);
        end
        resp_ready = 1'b1;
        sb.push_back('{rdata: 32'h11AB_3344, err: 1'b0});
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp idle req_ready", 32'(req_ready), 32'd1);
        chk("bp idle resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        chk("bp second valid", 32'(resp_valid), 32'd1);
        chk("bp second rdata", resp_rdata, e.rdata);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;

        // Reset while a response is pending; a request during reset must be ignored.
        @(negedge clk);
        v.write = 1; v.size = 2'b10; v.uns = 0; v.addr = 32'h30; v.wdata = 32'h0000_0077;
        drive(v);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst pre valid", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        v.wdata = 32'h0000_0099;
        drive(v);
        @(posedge clk);
        #1 begin
            rst_n = 1'b1;
            req_valid = 1'b0;
        end
        @(negedge clk);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        v.write = 0; v.wdata = 32'h0; v.exp_rdata = 32'h0000_0077; v.exp_err = 0;
        issue(v, 0, "rst committed");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked data memory for the execution-cycle datapath, replacing the single-port word memory used by the Storing stage. It serves one load/store request at a time over a valid/ready interface. It supports byte, halfword and word accesses with byte-lane writes and sign/zero-extended loads. The response is held until the consumer accepts it.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, at least 2.
- ADDR_WIDTH, 32: byte-address width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  load result; 0 for stores.
- resp_err  output  1  access rejected.

## Operation
- Storage: DEPTH × 32-bit words.
  - Word index = req_addr[2 +: log2(DEPTH)]; byte lane = req_addr[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
  - Lane 0 is bits [7:0] (little-endian).
- FSM states: IDLE, RESP.
  - IDLE: req_ready=1, resp_valid=0. On req_valid, the request is accepted at that edge and the FSM goes to RESP.
  - RESP: req_ready=0, resp_valid=1. On resp_ready, the FSM goes to IDLE; otherwise it stays in RESP with outputs stable.
- Store, committed at the accept edge:
  - Byte: writes lane addr[1:0] from wdata[7:0].
  - Halfword: writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0].
  - Word: writes all lanes.
  - Unselected lanes keep their contents.
- Load, captured at the accept edge:
  - The selected byte or halfword is placed in rdata[7:0] or rdata[15:0].
  - The upper bits are filled with the sign bit, or with 0 when req_unsigned=1. A word load ignores req_unsigned.
- Memory contents are not cleared by reset and are X until written.

## Timing
- Reset state: FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Latency: accept at edge N; resp_valid=1 from edge N through the edge where resp_ready=1.
- Minimum issue interval is 2 cycles, because req_ready is low in RESP; there is no request/response overlap.
- resp_rdata and resp_err are stable while resp_valid=1 and resp_ready=0.
- Read-after-write: a load accepted after a store sees the stored data.
- Requests with req_valid=1 in RESP are not accepted; the requester holds them until req_ready=1.
- Reset mid-operation: a pending response is dropped and the FSM returns to IDLE. A store already committed stays in memory.
- req_valid is ignored during a reset cycle.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - These requests are erroneous: halfword with addr[0]=1, word with addr[1:0]≠0, and req_size=11.
  - An erroneous request is still accepted and answered with resp_err=1 and resp_rdata=0, and nothing is written.
- DMEM_MISALIGN_CHECK_EN undefined:
  - resp_err is tied to 0.
  - Halfword ignores addr[0]; word and req_size=11 ignore addr[1:0]; size 11 is treated as a word.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Word store/load: store 0x00000056 at 0x34, store 0x00000036 at 0x40, then load 0x34 -> resp_rdata=0x00000056, resp_err=0. The store responses carry resp_rdata=0.
- Byte lanes: store word 0x11223344 at 0x10, store byte 0xAB at 0x12, load word 0x10 -> 0x11AB3344.
- Extension, using the word from the byte-lanes test:
  - Signed byte load 0x12 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
  - Signed halfword load 0x12 -> 0x000011AB.
- Backpressure: load with resp_ready=0 for 3 cycles, then 1.
  - resp_valid and resp_rdata are stable for 4 cycles and req_ready=0 throughout.
  - A second request held on req_valid is accepted only after return to IDLE.
- Misalignment and wrap, DEPTH=64:
  - With the macro, word store at 0x22 -> resp_err=1 and memory unchanged.
  - Without the macro, the same store writes word 0x20.
  - Store at 0x104 and load at 0x004 -> same data.
  - Reset asserted in RESP -> resp_valid=0 on the next cycle.
